// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes,
// FSM states, instruction classes and the ALU / write-back select codes.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI, C_ILL
  } cls_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FUN = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Map a raw opcode onto the instruction class the FSM sequences by.
  function automatic cls_t decode_op(input logic [6:0] op);
    cls_t c;
    case (op)
      OP_R:      c = C_R;
      OP_I:      c = C_I;
      OP_LOAD:   c = C_LOAD;
      OP_STORE:  c = C_STORE;
      OP_BRANCH: c = C_BRANCH;
      OP_JAL:    c = C_JAL;
      OP_LUI:    c = C_LUI;
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles while an access is outstanding and
// flags a timeout on the WAIT_MAX-th wait cycle so the FSM can halt.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt;

  // The current wait cycle is the WAIT_MAX-th when WAIT_MAX-1 already elapsed.
  assign timeout = active && !mem_ready && (cnt == CW'(WAIT_MAX - 1));

  // Clear whenever the access completes, the FSM is elsewhere, or it faults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!active || mem_ready || timeout) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory
// and write-back, drives datapath enables/selects, counts retired
// instructions and latches a sticky halt on illegal opcode or mem timeout.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       fun,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             mem_re,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t state;
  cls_t   cls;
  cls_t   id_cls;
  logic   timeout;
  logic   retire;
  logic   wait_active;

  // funct3 is decoded inside the ALU; the control path never needs it.
  logic   fun_unused;
  assign fun_unused = ^fun;

  assign id_cls      = decode_op(op);
  assign wait_active = (state == S_IF) || (state == S_MEM);

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait (
    .clk       (clk),
    .rst       (rst),
    .active    (wait_active),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  // State sequencing, latched instruction class and sticky halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IF;
      cls    <= C_R;
      halted <= 1'b0;
    end else begin
      case (state)
        S_IF: begin
          if (mem_ready) begin
            state <= S_ID;
          end else if (timeout) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
        end
        S_ID: begin
          cls <= id_cls;
          if (id_cls == C_ILL) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_EX;
          end
        end
        S_EX: begin
          case (cls)
            C_LOAD, C_STORE: state <= S_MEM;
            C_BRANCH:        state <= S_IF;
            default:         state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            state <= (cls == C_LOAD) ? S_WB : S_IF;
          end else if (timeout) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
        end
        S_WB:    state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  // An instruction retires on the cycle it leaves its final state.
  assign retire = ((state == S_EX)  && (cls == C_BRANCH)) ||
                  ((state == S_MEM) && (cls == C_STORE) && mem_ready) ||
                   (state == S_WB);

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // Per-state enables and selects; forced quiet while rst is high so no
  // partial access or write escapes once reset rises.
  always_comb begin
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    if (!rst) begin
      case (state)
        S_IF: begin
          mem_re = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        S_EX: begin
          case (cls)
            C_R: alu_op = ALU_FUN;
            C_I: begin
              alu_src_b = 1'b1;
              alu_op    = ALU_FUN;
            end
            C_LOAD, C_STORE, C_LUI: alu_src_b = 1'b1;
            C_BRANCH: begin
              alu_op = ALU_SUB;
              pc_we  = br_taken;
              pc_sel = 1'b1;
            end
            C_JAL: begin
              alu_src_a = 1'b1;
              alu_src_b = 1'b1;
              pc_we     = 1'b1;
              pc_sel    = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_addr_sel = 1'b1;
          if (cls == C_LOAD) begin
            mem_re = 1'b1;
          end else if (cls == C_STORE) begin
            mem_we = 1'b1;
          end
        end
        S_WB: begin
          rf_we = 1'b1;
          case (cls)
            C_LOAD:  wb_sel = WB_MEM;
            C_JAL:   wb_sel = WB_PC4;
            default: wb_sel = WB_ALU;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its states, checking the enable/select bundle, retire count and halt flag.
module tb_multicycle_ctrl;

  localparam logic [6:0] T_R      = 7'b0110011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_BAD    = 7'b1111111;

  // {ir_we,pc_we,pc_sel,mem_re,mem_we,mem_addr_sel,rf_we,wb_sel,a,b,alu_op}
  localparam logic [12:0] IF_RDY  = 13'b1_1_0_1_0_0_0_00_0_0_00;
  localparam logic [12:0] IF_WAIT = 13'b0_0_0_1_0_0_0_00_0_0_00;
  localparam logic [12:0] IDLE    = 13'b0_0_0_0_0_0_0_00_0_0_00;
  localparam logic [12:0] EX_R    = 13'b0_0_0_0_0_0_0_00_0_0_10;
  localparam logic [12:0] EX_LS   = 13'b0_0_0_0_0_0_0_00_0_1_00;
  localparam logic [12:0] EX_BT   = 13'b0_1_1_0_0_0_0_00_0_0_01;
  localparam logic [12:0] EX_BN   = 13'b0_0_1_0_0_0_0_00_0_0_01;
  localparam logic [12:0] EX_JAL  = 13'b0_1_1_0_0_0_0_00_1_1_00;
  localparam logic [12:0] MEM_LD  = 13'b0_0_0_1_0_1_0_00_0_0_00;
  localparam logic [12:0] MEM_ST  = 13'b0_0_0_0_1_1_0_00_0_0_00;
  localparam logic [12:0] WB_ALU  = 13'b0_0_0_0_0_0_1_00_0_0_00;
  localparam logic [12:0] WB_LD   = 13'b0_0_0_0_0_0_1_01_0_0_00;
  localparam logic [12:0] WB_JAL  = 13'b0_0_0_0_0_0_1_10_0_0_00;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  fun;
  logic        mem_ready;
  logic        br_taken;
  logic        ir_we, pc_we, pc_sel, mem_re, mem_we, mem_addr_sel, rf_we;
  logic [1:0]  wb_sel;
  logic        alu_src_a, alu_src_b;
  logic [1:0]  alu_op;
  logic        halted;
  logic [31:0] retired;
  logic [12:0] ctl;

  int vectors     = 0;
  int miscompares = 0;

  multicycle_ctrl #(
    .CNT_W    (32),
    .WAIT_MAX (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .fun          (fun),
    .mem_ready    (mem_ready),
    .br_taken     (br_taken),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .halted       (halted),
    .retired      (retired)
  );

  assign ctl = {ir_we, pc_we, pc_sel, mem_re, mem_we, mem_addr_sel, rf_we,
                wb_sel, alu_src_a, alu_src_b, alu_op};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; op = T_R; fun = 3'd0; mem_ready = 1'b1; br_taken = 1'b0;
    tick(); #1;
    vectors++;
    if (ctl !== IDLE) begin miscompares++; $display("FAIL rst_ctl got=%b exp=%b", ctl, IDLE); end
    vectors++;
    if (retired !== 32'd0) begin miscompares++; $display("FAIL rst_retired got=%0d exp=0", retired); end
    vectors++;
    if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted got=%b exp=0", halted); end
    rst = 1'b0; #1;
    vectors++;
    if (ctl !== IF_RDY) begin miscompares++; $display("FAIL rst_release_if got=%b exp=%b", ctl, IF_RDY); end
  endtask

  task automatic test_r_type();
    op = T_R; mem_ready = 1'b1; #1;
    vectors++;
    if (ctl !== IF_RDY) begin miscompares++; $display("FAIL r_if got=%b exp=%b", ctl, IF_RDY); end
    tick(); #1;
    vectors++;
    if (ctl !== IDLE) begin miscompares++; $display("FAIL r_id got=%b exp=%b", ctl, IDLE); end
    tick(); #1;
    vectors++;
    if (ctl !== EX_R) begin miscompares++; $display("FAIL r_ex got=%b exp=%b", ctl, EX_R); end
    tick(); #1;
    vectors++;
    if (ctl !== WB_ALU) begin miscompares++; $display("FAIL r_wb got=%b exp=%b", ctl, WB_ALU); end
    vectors++;
    if (retired !== 32'd0) begin miscompares++; $display("FAIL r_retired_wb got=%0d exp=0", retired); end
    tick(); #1;
    vectors++;
    if (retired !== 32'd1) begin miscompares++; $display("FAIL r_retired got=%0d exp=1", retired); end
    vectors++;
    if (ctl !== IF_RDY) begin miscompares++; $display("FAIL r_next_if got=%b exp=%b", ctl, IF_RDY); end
  endtask

  task automatic test_load_wait();
    op = T_LOAD; #1;
    tick(); #1;
    vectors++;
    if (ctl !== IDLE) begin miscompares++; $display("FAIL ld_id got=%b exp=%b", ctl, IDLE); end
    tick(); #1;
    vectors++;
    if (ctl !== EX_LS) begin miscompares++; $display("FAIL ld_ex got=%b exp=%b", ctl, EX_LS); end
    tick(); mem_ready = 1'b0; #1;
    vectors++;
    if (ctl !== MEM_LD) begin miscompares++; $display("FAIL ld_mem_w1 got=%b exp=%b", ctl, MEM_LD); end
    tick(); #1;
    vectors++;
    if (ctl !== MEM_LD) begin miscompares++; $display("FAIL ld_mem_w2 got=%b exp=%b", ctl, MEM_LD); end
    tick(); mem_ready = 1'b1; #1;
    vectors++;
    if (ctl !== MEM_LD) begin miscompares++; $display("FAIL ld_mem_rdy got=%b exp=%b", ctl, MEM_LD); end
    tick(); #1;
    vectors++;
    if (ctl !== WB_LD) begin miscompares++; $display("FAIL ld_wb got=%b exp=%b", ctl, WB_LD); end
    tick(); #1;
    vectors++;
    if (retired !== 32'd2) begin miscompares++; $display("FAIL ld_retired got=%0d exp=2", retired); end
    vectors++;
    if (ctl !== IF_RDY) begin miscompares++; $display("FAIL ld_next_if got=%b exp=%b", ctl, IF_RDY); end
  endtask

  task automatic test_branch();
    op = T_BRANCH; br_taken = 1'b1; #1;
    tick(); tick(); #1;
    vectors++;
    if (ctl !== EX_BT) begin miscompares++; $display("FAIL br_taken_ex got=%b exp=%b", ctl, EX_BT); end
    tick(); #1;
    vectors++;
    if (retired !== 32'd3) begin miscompares++; $display("FAIL br_taken_retired got=%0d exp=3", retired); end
    vectors++;
    if (ctl !== IF_RDY) begin miscompares++; $display("FAIL br_taken_next_if got=%b exp=%b", ctl, IF_RDY); end
    br_taken = 1'b0;
    tick(); #1;
    vectors++;
    if (ctl !== IDLE) begin miscompares++; $display("FAIL br_nt_id got=%b exp=%b", ctl, IDLE); end
    tick(); #1;
    vectors++;
    if (ctl !== EX_BN) begin miscompares++; $display("FAIL br_nt_ex got=%b exp=%b", ctl, EX_BN); end
    tick(); #1;
    vectors++;
    if (retired !== 32'd4) begin miscompares++; $display("FAIL br_nt_retired got=%0d exp=4", retired); end
  endtask

  task automatic test_jal_store_lui();
    op = T_JAL; #1;
    tick(); tick(); #1;
    vectors++;
    if (ctl !== EX_JAL) begin miscompares++; $display("FAIL jal_ex got=%b exp=%b", ctl, EX_JAL); end
    tick(); #1;
    vectors++;
    if (ctl !== WB_JAL) begin miscompares++; $display("FAIL jal_wb got=%b exp=%b", ctl, WB_JAL); end
    tick(); #1;
    vectors++;
    if (retired !== 32'd5) begin miscompares++; $display("FAIL jal_retired got=%0d exp=5", retired); end
    op = T_STORE;
    tick(); tick(); #1;
    vectors++;
    if (ctl !== EX_LS) begin miscompares++; $display("FAIL st_ex got=%b exp=%b", ctl, EX_LS); end
    tick(); #1;
    vectors++;
    if (ctl !== MEM_ST) begin miscompares++; $display("FAIL st_mem got=%b exp=%b", ctl, MEM_ST); end
    tick(); #1;
    vectors++;
    if (retired !== 32'd6) begin miscompares++; $display("FAIL st_retired got=%0d exp=6", retired); end
    vectors++;
    if (ctl !== IF_RDY) begin miscompares++; $display("FAIL st_next_if got=%b exp=%b", ctl, IF_RDY); end
    op = T_LUI;
    tick(); tick(); #1;
    vectors++;
    if (ctl !== EX_LS) begin miscompares++; $display("FAIL lui_ex got=%b exp=%b", ctl, EX_LS); end
    tick(); #1;
    vectors++;
    if (ctl !== WB_ALU) begin miscompares++; $display("FAIL lui_wb got=%b exp=%b", ctl, WB_ALU); end
    tick(); #1;
    vectors++;
    if (retired !== 32'd7) begin miscompares++; $display("FAIL lui_retired got=%0d exp=7", retired); end
  endtask

  task automatic test_illegal();
    op = T_BAD; #1;
    tick(); #1;
    vectors++;
    if (halted !== 1'b0) begin miscompares++; $display("FAIL ill_id_halted got=%b exp=0", halted); end
    tick(); #1;
    vectors++;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL ill_halted got=%b exp=1", halted); end
    for (int i = 0; i < 20; i++) begin
      tick(); mem_ready = i[0]; br_taken = 1'b1; #1;
      vectors++;
      if (ctl !== IDLE || halted !== 1'b1 || retired !== 32'd7) begin
        miscompares++;
        $display("FAIL ill_hold[%0d] ctl=%b halted=%b retired=%0d exp ctl=%b halted=1 retired=7",
                 i, ctl, halted, retired, IDLE);
      end
    end
    rst = 1'b1; #1;
    vectors++;
    if (halted !== 1'b0 || retired !== 32'd0 || ctl !== IDLE) begin
      miscompares++;
      $display("FAIL ill_rst halted=%b retired=%0d ctl=%b exp 0/0/%b", halted, retired, ctl, IDLE);
    end
    tick();
    rst = 1'b0; op = T_R; mem_ready = 1'b0; br_taken = 1'b0;
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 15; i++) begin
      #1;
      vectors++;
      if (ctl !== IF_WAIT || halted !== 1'b0) begin
        miscompares++;
        $display("FAIL to_wait[%0d] ctl=%b halted=%b exp ctl=%b halted=0", i, ctl, halted, IF_WAIT);
      end
      tick();
    end
    #1;
    vectors++;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL to_halted got=%b exp=1", halted); end
    vectors++;
    if (ctl !== IDLE) begin miscompares++; $display("FAIL to_ctl got=%b exp=%b", ctl, IDLE); end
    rst = 1'b1; #1;
    tick();
    rst = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic test_reset_mid_store();
    op = T_R; #1;
    tick(); tick(); tick(); tick(); #1;
    vectors++;
    if (retired !== 32'd1) begin miscompares++; $display("FAIL mid_pre_retired got=%0d exp=1", retired); end
    op = T_STORE;
    tick(); tick(); tick(); mem_ready = 1'b0; #1;
    vectors++;
    if (ctl !== MEM_ST) begin miscompares++; $display("FAIL mid_mem got=%b exp=%b", ctl, MEM_ST); end
    #1 rst = 1'b1; #1;
    vectors++;
    if (ctl !== IDLE) begin miscompares++; $display("FAIL mid_rst_ctl got=%b exp=%b", ctl, IDLE); end
    vectors++;
    if (retired !== 32'd0) begin miscompares++; $display("FAIL mid_rst_retired got=%0d exp=0", retired); end
    tick();
    rst = 1'b0; mem_ready = 1'b1; #1;
    vectors++;
    if (ctl !== IF_RDY) begin miscompares++; $display("FAIL mid_back_if got=%b exp=%b", ctl, IF_RDY); end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_load_wait();
    test_branch();
    test_jal_store_lui();
    test_illegal();
    test_timeout();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
